// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals shared by the write arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    s_valid;
    logic [NREQ-1:0]    s_last;
    logic [NREQ*DW-1:0] s_data;
    logic [NREQ-1:0]    s_ready;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      fifo_wdata;
    logic               fifo_wen;
    logic               fifo_full;
    logic               fifo_afull;
    logic               busy;
    logic [31:0]        beat_total;

    modport slave (
        input  s_valid, s_last, s_data, fifo_full, fifo_afull,
        output s_ready, gnt, fifo_wdata, fifo_wen, busy, beat_total
    );

    modport master (
        output s_valid, s_last, s_data, fifo_full, fifo_afull,
        input  s_ready, gnt, fifo_wdata, fifo_wen, busy, beat_total
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one async-FIFO write port between NREQ sources.
// Whole bursts are granted, stalled only by fifo_full; fifo_afull only blocks new grants.
module fifo_wr_arbiter #(
    parameter int NREQ      = 2,
    parameter int DW        = 16,
    parameter int MAX_BURST = 64
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     total_q, total_d;

    logic            in_burst;
    logic            accept;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand [NREQ];
    logic [DW-1:0]   data_arr [NREQ];

    // cand[k] is requester (ptr+1+k) mod NREQ, i.e. the round-robin search order.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum      = {1'b0, ptr_q} + (IW+1)'(gi + 1);
        assign cand[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
        assign data_arr[gi] = bus.s_data[gi*DW +: DW];
    end

    assign in_burst = (state_q == ST_BURST);
    assign accept   = in_burst & bus.s_valid[gidx_q] & ~bus.fifo_full;

    assign bus.gnt        = gnt_q;
    assign bus.busy       = in_burst;
    assign bus.beat_total = total_q;
    assign bus.s_ready    = (in_burst && !bus.fifo_full) ? gnt_q : '0;
    assign bus.fifo_wen   = accept;
    assign bus.fifo_wdata = data_arr[gidx_q];

    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && bus.s_valid[cand[k]]) begin
                win_found = 1'b1;
                win_idx   = cand[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found && !bus.fifo_afull) begin
                    state_d = ST_BURST;
                    gnt_d   = NREQ'(1) << win_idx;
                    gidx_d  = win_idx;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (accept) begin
                    cnt_d   = cnt_q + 1'b1;
                    total_d = total_q + 32'd1;
                    // Truncated packets keep their remainder and re-arbitrate behind others.
                    if (bus.s_last[gidx_q] || cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        ptr_d   = gidx_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(NREQ - 1);
            cnt_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: packets are loaded per requester, a list-level round-robin model
// predicts the write stream, and a negedge monitor pops and compares each FIFO write.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 3;
    localparam int DW        = 16;
    localparam int MAX_BURST = 4;

    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int            req;
        logic [DW-1:0] data;
        bit            eob;
    } exp_t;

    beat_t src_q [NREQ][$];
    exp_t  exp_q [$];
    exp_t  mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int tot_exp = 0;
    int model_ptr = NREQ - 1;
    int p_full = 0;
    int p_afull = 0;
    int p_bubble = 0;
    bit prev_eob = 0;
    bit prev_arb = 0;
    bit prev_afull_idle = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < NREQ; i++)
            if (src_q[i].size() > 0) return 1'b1;
        return exp_q.size() > 0;
    endfunction

    function automatic void add_packet(int r, int len, bit rnd);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = rnd ? DW'($urandom) : DW'(k + 1);
            b.last = (k == len - 1);
            src_q[r].push_back(b);
        end
    endfunction

    // Reference: walk the loaded packet lists, serving requesters round-robin in
    // bursts that end on a last beat or after MAX_BURST beats.
    function automatic void build_expected();
        int    pos [NREQ];
        int    r;
        int    n;
        bit    found;
        bit    e_end;
        beat_t b;
        exp_t  e;
        foreach (pos[i]) pos[i] = 0;
        forever begin
            found = 1'b0;
            r = 0;
            for (int k = 1; k <= NREQ && !found; k++) begin
                r = (model_ptr + k) % NREQ;
                if (pos[r] < src_q[r].size()) found = 1'b1;
            end
            if (!found) break;
            n = 0;
            forever begin
                b = src_q[r][pos[r]];
                pos[r]++;
                n++;
                e_end = b.last || (n == MAX_BURST);
                e.req = r;
                e.data = b.data;
                e.eob = e_end;
                exp_q.push_back(e);
                if (e_end) break;
            end
            model_ptr = r;
        end
    endfunction

    task automatic drive_inputs();
        bus.fifo_full  = (int'($urandom_range(99)) < p_full);
        bus.fifo_afull = (int'($urandom_range(99)) < p_afull);
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                bus.s_data[i*DW +: DW] = src_q[i][0].data;
                bus.s_last[i]  = src_q[i][0].last;
                // Sources only hiccup while granted, so arbitration order stays predictable.
                bus.s_valid[i] = !(bus.gnt[i] && int'($urandom_range(99)) < p_bubble);
            end else begin
                bus.s_data[i*DW +: DW] = DW'($urandom);
                bus.s_last[i]  = 1'b0;
                bus.s_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge wclk);
        acc = bus.s_valid & bus.s_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive_inputs();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        model_ptr = NREQ - 1;
        bus.s_valid = '0;
        bus.s_last = '0;
        bus.fifo_full = 1'b0;
        bus.fifo_afull = 1'b0;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        clear_all();
        repeat (2) @(posedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    task automatic run_phase(string name, int budget);
        int cyc;
        cyc = 0;
        build_expected();
        drive_inputs();
        while (any_pending() && cyc < budget) begin
            step();
            cyc++;
        end
        n_cmp++;
        if (cyc >= budget) begin
            n_err++;
            $display("FAIL %s_timeout: %0d writes outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), cyc);
            do_reset();
        end
        step();
        step();
    endtask

    // Monitor: protocol properties every cycle, scoreboard pop on every FIFO write.
    initial begin
        forever begin
            @(negedge wclk);
            if (wrst) begin
                tot_exp = 0;
                prev_eob = 0;
                prev_arb = 0;
                prev_afull_idle = 0;
            end else begin
                check("beat_total", bus.beat_total, tot_exp);
                check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
                check("busy", 32'(bus.busy), 32'(bus.gnt != '0));
                check("s_ready", 32'(bus.s_ready), bus.fifo_full ? 32'd0 : 32'(bus.gnt));
                check("fifo_wen", 32'(bus.fifo_wen),
                      32'((|(bus.gnt & bus.s_valid)) && !bus.fifo_full));
                if (prev_eob) check("gap_after_burst", 32'(bus.gnt), 32'd0);
                if (prev_arb) check("grant_latency", 32'(bus.gnt != '0), 32'd1);
                if (prev_afull_idle) check("afull_hold", 32'(bus.gnt), 32'd0);
                prev_eob = 0;
                if (bus.fifo_wen) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: got data %0h, expected no write", bus.fifo_wdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wdata", 32'(bus.fifo_wdata), 32'(mon_e.data));
                        check("write_gnt", 32'(bus.gnt), 32'(1) << mon_e.req);
                        tot_exp++;
                        prev_eob = mon_e.eob;
                    end
                end
                prev_arb = (bus.gnt == '0) && (|bus.s_valid) && !bus.fifo_afull;
                prev_afull_idle = (bus.gnt == '0) && bus.fifo_afull;
            end
        end
    end

    initial begin
        int base;
        int npk;
        wrst = 1'b1;
        bus.s_data = '0;
        clear_all();
        repeat (3) @(posedge wclk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_wen", 32'(bus.fifo_wen), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_beat_total", bus.beat_total, 32'd0);
        wrst = 1'b0;
        @(posedge wclk);
        #1;

        add_packet(0, 4, 1'b0);
        run_phase("single_req", 200);
        check("single_req_total", bus.beat_total, 32'd4);

        add_packet(0, 3, 1'b1); add_packet(0, 3, 1'b1);
        add_packet(1, 3, 1'b1); add_packet(1, 3, 1'b1);
        run_phase("two_req", 300);
        check("two_req_total", bus.beat_total, 32'd16);

        p_full = 35;
        add_packet(0, 8, 1'b1);
        run_phase("full_stall", 500);
        p_full = 0;

        add_packet(0, 10, 1'b1);
        add_packet(1, 3, 1'b1); add_packet(1, 3, 1'b1); add_packet(1, 3, 1'b1);
        run_phase("truncation", 500);

        p_afull = 50;
        add_packet(0, 6, 1'b1); add_packet(2, 5, 1'b1);
        run_phase("afull", 500);
        p_afull = 0;

        for (int ph = 0; ph < 30; ph++) begin
            p_full   = int'($urandom_range(40));
            p_afull  = int'($urandom_range(40));
            p_bubble = int'($urandom_range(30));
            for (int r = 0; r < NREQ; r++) begin
                npk = int'($urandom_range(3));
                for (int k = 0; k < npk; k++) add_packet(r, int'($urandom_range(1, 9)), 1'b1);
            end
            if (!any_pending()) add_packet(int'($urandom_range(NREQ - 1)), 2, 1'b1);
            run_phase("random", 3000);
        end
        p_full = 0;
        p_afull = 0;
        p_bubble = 0;

        add_packet(0, 8, 1'b1);
        build_expected();
        drive_inputs();
        base = tot_exp;
        for (int c = 0; c < 50 && (tot_exp - base) < 3; c++) step();
        check("rst_mid_reached", 32'((tot_exp - base) >= 3), 32'd1);
        #1;
        wrst = 1'b1;
        #1;
        check("async_rst_gnt", 32'(bus.gnt), 32'd0);
        check("async_rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("async_rst_wen", 32'(bus.fifo_wen), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_beat_total", bus.beat_total, 32'd0);
        clear_all();
        repeat (2) @(posedge wclk);
        #1;
        wrst = 1'b0;
        @(posedge wclk);
        #1;

        add_packet(0, 3, 1'b1); add_packet(1, 3, 1'b1); add_packet(2, 3, 1'b1);
        run_phase("after_reset", 300);
        check("after_reset_total", bus.beat_total, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
